// File: rtl/uart_pkg.sv
// Shared UART types and default constants.
// The rx state enum always carries PARITY so that builds with and without
// UART_RX_PARITY_EN use the same encoding.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4,
    PARITY = 3'd5
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous boundary inputs.
// Both flops load RESET_VAL while rst is high, so the output starts at a
// known level. For an idle-high line, use RESET_VAL = 1.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic sclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // The first flop may go metastable; only the second flop drives q.
  always_ff @(posedge sclk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// Serial receiver: recovers 8N1 frames (LSB first) from an idle-high line.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit between the
// data and stop bits, plus the rx_parity_err strobe.
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure. rx_data
// holds the byte from that strobe until the next good frame.
//
// The stop-bit decision is registered once (stop_done/stop_bit) before it
// drives the strobes. rx_valid therefore rises 3+N/2+9N cycles after the
// edge that first captures the falling rxd. The FSM returns to IDLE on the
// same edge, so a start bit that directly follows the stop bit is accepted.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 rx_parity_err,
`endif
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  logic rxd_s;

  rx_state_e            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bitidx, bitidx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 stop_done, stop_done_n;
  logic                 stop_bit, stop_bit_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_bit_n;
  logic                 par_ok;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .sclk (sclk),
    .rst  (rst),
    .d    (rxd),
    .q    (rxd_s)
  );

  // FSM state, counters, shift register and registered stop-bit decision.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bitidx    <= '0;
      shift     <= '0;
      stop_done <= 1'b0;
      stop_bit  <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bitidx    <= bitidx_n;
      shift     <= shift_n;
      stop_done <= stop_done_n;
      stop_bit  <= stop_bit_n;
`ifdef UART_RX_PARITY_EN
      par_bit   <= par_bit_n;
`endif
    end
  end

  // Next-state logic: count to each bit's sample point and act on rxd_s there.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CW'(1);
    bitidx_n    = bitidx;
    shift_n     = shift;
    stop_done_n = 1'b0;
    stop_bit_n  = stop_bit;
`ifdef UART_RX_PARITY_EN
    par_bit_n   = par_bit;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxd_s) state_n = START;
      end
      START: begin
        // Mid-point of the start bit. A line that is high again here was a glitch.
        if (cnt == HALF_LAST) begin
          cnt_n    = '0;
          bitidx_n = '0;
          state_n  = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n    = '0;
          shift_n  = {rxd_s, shift[DATA_BITS-1:1]};
          bitidx_n = bitidx + BW'(1);
          if (bitidx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          par_bit_n = rxd_s;
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n       = '0;
          stop_done_n = 1'b1;
          stop_bit_n  = rxd_s;
          state_n     = rxd_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // A held-low line stays here, so it raises only one frame error.
        cnt_n = '0;
        if (rxd_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data plus parity bit hold an even number of ones.
  assign par_ok = (par_bit == ((^shift) ^ PARITY_ODD));
`endif

  // Output strobes and the data holding register, one cycle after the stop sample.
  always_ff @(posedge sclk) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      if (stop_done) begin
        if (!stop_bit) begin
          rx_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
        end else if (!par_ok) begin
          rx_parity_err <= 1'b1;
`endif
        end else begin
          rx_valid <= 1'b1;
          rx_data  <= shift;
        end
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial-line receiver for the single-bit, idle-high output lines driven by the team's transmit-side blocks.
- Samples an asynchronous rxd input, detects start bits, and recovers 8N1 frames, LSB first.
- Presents each byte on a parallel bus with a one-cycle valid strobe.
- Sits at the chip boundary, in front of command-parsing logic.

Parameters:
- CLKS_PER_BIT, 868, sclk cycles per serial bit; even, minimum 4 (868 = 100 MHz / 115200).
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- sclk  in  1  system clock
- rst  in  1  reset
- rxd  in  1  asynchronous serial input; idle level 1
- rx_data  out  DATA_BITS  last good byte; bit 0 is the first received data bit
- rx_valid  out  1  one-cycle pulse; rx_data is new this cycle
- rx_frame_err  out  1  one-cycle pulse; stop bit sampled 0
- rx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: rst is synchronous, active-high, on clock sclk.
  - While rst is high: state=IDLE, bit counter and cycle counter=0, synchroniser flops=1.
  - Outputs in reset: rx_data=0, rx_valid=0, rx_frame_err=0, rx_busy=0.
  - rst asserted mid-frame aborts the frame with no strobe. The first start bit is accepted only after rst deasserts and the synchronised line reads 1.
- Synchroniser: 2-flop chain on rxd, reset to 1. rxd_s lags rxd by 2 cycles; only rxd_s is used downstream.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rxd_s==0 -> START with cnt=0.
  - The cycle where this is first seen is t0.
- START:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT/2-1 (t0+N/2), sample rxd_s.
  - Sample 0 -> DATA with cnt=0, bitidx=0.
  - Sample 1 -> IDLE. The low pulse was a glitch; no strobe is raised.
- DATA:
  - At cnt==N-1, shift rxd_s into the MSB of the shift register (right shift), reset cnt, increment bitidx.
  - After the DATA_BITS-th sample -> STOP.
  - Data samples fall at t0+N/2+k*N, for k=1..DATA_BITS.
- STOP:
  - At cnt==N-1, sample rxd_s.
  - Sample 1 -> rx_data<=shift register; rx_valid=1 on the next cycle; -> IDLE.
  - Sample 0 -> rx_frame_err=1 on the next cycle; rx_data unchanged; -> BREAK.
- BREAK: wait until rxd_s==1, then -> IDLE. A held-low line therefore yields exactly one frame_err.
- End-to-end latency, with N=CLKS_PER_BIT and DATA_BITS=8:
  - rx_valid is high 3+N/2+9N cycles after the sclk edge that first captures rxd=0.
  - For N=8 this is 79 cycles.
- Back-to-back frames: a new start bit seen in the IDLE cycle immediately after STOP is accepted. No gap is required beyond the stop bit.
- Strobes:
  - rx_valid and rx_frame_err are never high together.
  - Each is high for exactly one cycle.
- Counter widths: cnt is $clog2(CLKS_PER_BIT) bits; bitidx is $clog2(DATA_BITS+1) bits.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Parameter PARITY_ODD (default 0, even parity) is added.
  - Port rx_parity_err (out, 1, one-cycle pulse) is added.
  - A PARITY state sits between DATA and STOP, sampled at t0+N/2+(DATA_BITS+1)*N. STOP moves one bit later.
  - On a parity mismatch with a good stop bit: rx_parity_err pulses, rx_valid does not pulse, and rx_data is unchanged.
  - Latency becomes 3+N/2+10N.
- When undefined: no PARITY state, no rx_parity_err port, 8N1 only.

Decomposition:
- Package uart_pkg holds:
  - the rx state enum (IDLE, START, DATA, STOP, BREAK, PARITY);
  - the default constants UART_CLKS_PER_BIT=868 and UART_DATA_BITS=8.
- One sub-module, sync_2ff: a single-bit 2-flop synchroniser with a parameterised reset value (1 here). It is reusable by other boundary inputs.

Test Plan:
- N=8; rst high 5 cycles, then idle line -> all outputs 0, rx_busy 0, no strobes.
- N=8; send 0xA5 as 8N1 -> rx_valid pulse exactly 79 cycles after the rxd falling edge, rx_data=0xA5, rx_frame_err stays 0.
- Send 0x00, then 0xFF back-to-back with zero idle gap -> two rx_valid pulses 80 cycles apart, data 0x00 then 0xFF.
- Drive rxd low for 3 cycles in idle -> START aborts to IDLE, no strobe; a following 0x3C frame is received correctly.
- Send 0x55 with stop bit 0, then hold the line low for 40 bit times -> exactly one rx_frame_err pulse, rx_data keeps its previous value, rx_busy stays high until the line returns to 1.
- Assert rst at data bit 4 of 0x81, deassert it, then send 0x81 again -> no strobe for the aborted frame; the second frame gives rx_data=0x81. With UART_RX_PARITY_EN, even parity and a wrong parity bit -> rx_parity_err pulses and rx_valid does not.
